// File: rtl/motor_pwm_if.sv
// motor_pwm_if: command and bridge-pin bundle between the motion controller and the multi-channel PWM driver
interface motor_pwm_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 14
);
    logic [NUM_CH*CNT_W-1:0] duty_in;
    logic [NUM_CH-1:0]       dir_in;
    logic [NUM_CH-1:0]       brake_in;
    logic                    upd_req;
    logic                    upd_pending;
    logic                    period_start;
    logic [NUM_CH-1:0]       m_a;
    logic [NUM_CH-1:0]       m_b;

    modport master (
        output duty_in, dir_in, brake_in, upd_req,
        input  upd_pending, period_start, m_a, m_b
    );

    modport slave (
        input  duty_in, dir_in, brake_in, upd_req,
        output upd_pending, period_start, m_a, m_b
    );
endinterface

// File: rtl/motor_pwm_multi.sv
// motor_pwm_multi: NUM_CH-channel H-bridge PWM with one shared period counter and double-buffered duty/dir/brake.
// Optional dead time on direction reversal is enabled by defining PWM_DEADTIME_EN.
module motor_pwm_multi #(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 14,
    parameter int PERIOD   = 11000,
    parameter int DEAD_CYC = 16
) (
    input logic        clk,
    input logic        rst,
    motor_pwm_if.slave bus
);
    logic [CNT_W-1:0]             cnt;
    logic                         wrap;
    logic                         pending;
    logic [NUM_CH-1:0][CNT_W-1:0] sh_duty;
    logic [NUM_CH-1:0][CNT_W-1:0] act_duty;
    logic [NUM_CH-1:0][CNT_W-1:0] ld_duty;
    logic [NUM_CH-1:0]            sh_dir, sh_brake, act_dir, act_brake;
    logic [NUM_CH-1:0]            ld_dir, ld_brake;
    logic                         ld_en;
    logic [NUM_CH-1:0]            dead;
    logic [NUM_CH-1:0]            a_nxt, b_nxt;

    assign wrap     = cnt == CNT_W'(PERIOD - 1);
    assign ld_en    = wrap & (bus.upd_req | pending);
    assign ld_duty  = bus.upd_req ? bus.duty_in  : sh_duty;
    assign ld_dir   = bus.upd_req ? bus.dir_in   : sh_dir;
    assign ld_brake = bus.upd_req ? bus.brake_in : sh_brake;
    assign bus.upd_pending = pending;

    // free-running period counter, 0..PERIOD-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= wrap ? '0 : cnt + 1'b1;
    end

    // shadow capture and period-boundary transfer into the active set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_duty   <= '0;
            sh_dir    <= '1;
            sh_brake  <= '0;
            act_duty  <= '0;
            act_dir   <= '1;
            act_brake <= '0;
            pending   <= 1'b0;
        end else begin
            if (bus.upd_req) begin
                sh_duty  <= bus.duty_in;
                sh_dir   <= bus.dir_in;
                sh_brake <= bus.brake_in;
            end
            if (ld_en) begin
                act_duty  <= ld_duty;
                act_dir   <= ld_dir;
                act_brake <= ld_brake;
            end
            pending <= wrap ? 1'b0 : (pending | bus.upd_req);
        end
    end

`ifdef PWM_DEADTIME_EN
    // flag channels whose direction reverses at this boundary; held for the whole period
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       dead <= '0;
        else if (wrap) dead <= ld_en ? (ld_dir ^ act_dir) & ~ld_brake : '0;
    end
`else
    assign dead = '0;
`endif

    // compare and bridge mapping; dead-time window blanks the PWM term only, brake always wins
    always_comb begin
        a_nxt = '0;
        b_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            logic pwm;
            pwm      = (cnt < act_duty[i]) & ~(dead[i] & (cnt < CNT_W'(DEAD_CYC)));
            a_nxt[i] = act_brake[i] | (act_dir[i] & pwm);
            b_nxt[i] = act_brake[i] | (~act_dir[i] & pwm);
        end
    end

    // registered pins and period marker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.m_a          <= '0;
            bus.m_b          <= '0;
            bus.period_start <= 1'b0;
        end else begin
            bus.m_a          <= a_nxt;
            bus.m_b          <= b_nxt;
            bus.period_start <= wrap;
        end
    end
endmodule

// File: tb/tb_motor_pwm_multi.sv
// tb_motor_pwm_multi: directed checks of the multi-channel PWM driver with PERIOD=20, CNT_W=5, NUM_CH=2
module tb_motor_pwm_multi;
    localparam int NUM_CH   = 2;
    localparam int CNT_W    = 5;
    localparam int PERIOD   = 20;
    localparam int DEAD_CYC = 3;
`ifdef PWM_DEADTIME_EN
    localparam int EXP_REV_HIGH  = 7;
    localparam int EXP_REV_FIRST = 4;
`else
    localparam int EXP_REV_HIGH  = 10;
    localparam int EXP_REV_FIRST = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    motor_pwm_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    motor_pwm_multi #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PERIOD(PERIOD), .DEAD_CYC(DEAD_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic drive(input logic [4:0] d0, input logic [4:0] d1, input logic [1:0] dir, input logic [1:0] brake);
        bus.duty_in  = {d1, d0};
        bus.dir_in   = dir;
        bus.brake_in = brake;
    endtask

    task automatic load(input logic [4:0] d0, input logic [4:0] d1, input logic [1:0] dir, input logic [1:0] brake);
        drive(d0, d1, dir, brake);
        bus.upd_req = 1'b1;
        @(negedge clk);
        bus.upd_req = 1'b0;
    endtask

    task automatic sync_wrap();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.period_start && n < 4 * PERIOD);
        checks++;
        if (!bus.period_start) begin
            fails++;
            $display("FAIL sync_wrap: period_start not seen within %0d cycles", n);
        end
    endtask

    task automatic measure(input int ch, output int ha, output int hb, output int ps, output int pd, output int ov, output int first);
        ha = 0; hb = 0; ps = 0; pd = 0; ov = 0; first = -1;
        for (int i = 1; i <= PERIOD; i++) begin
            @(negedge clk);
            ha += int'(bus.m_a[ch]);
            hb += int'(bus.m_b[ch]);
            ps += int'(bus.period_start);
            pd += int'(bus.upd_pending);
            ov += int'(bus.m_a[ch] & bus.m_b[ch]);
            if (first < 0 && (bus.m_a[ch] | bus.m_b[ch])) first = i;
        end
    endtask

    task automatic test_reset();
        int first = 0;
        rst = 1'b1;
        bus.upd_req = 1'b0;
        drive(5'd0, 5'd0, 2'b11, 2'b00);
        repeat (3) @(negedge clk);
        checks++; if (bus.m_a !== 2'b00) begin fails++; $display("FAIL reset_m_a: got %b want 00", bus.m_a); end
        checks++; if (bus.m_b !== 2'b00) begin fails++; $display("FAIL reset_m_b: got %b want 00", bus.m_b); end
        checks++; if (bus.upd_pending !== 1'b0) begin fails++; $display("FAIL reset_pending: got %b want 0", bus.upd_pending); end
        checks++; if (bus.period_start !== 1'b0) begin fails++; $display("FAIL reset_period_start: got %b want 0", bus.period_start); end
        rst = 1'b0;
        for (int j = 1; j <= 3 * PERIOD; j++) begin
            @(negedge clk);
            if (bus.period_start) begin first = j; break; end
        end
        checks++; if (first !== PERIOD) begin fails++; $display("FAIL reset_first_period: got %0d want %0d", first, PERIOD); end
    endtask

    task automatic test_basic();
        int ha, hb, ps, pd, ov, fi;
        load(5'd5, 5'd0, 2'b11, 2'b00);
        sync_wrap();
        measure(0, ha, hb, ps, pd, ov, fi);
        checks++; if (ha !== 5) begin fails++; $display("FAIL basic_ch0_a: got %0d want 5", ha); end
        checks++; if (hb !== 0) begin fails++; $display("FAIL basic_ch0_b: got %0d want 0", hb); end
        checks++; if (ps !== 1) begin fails++; $display("FAIL basic_period_start: got %0d want 1", ps); end
        checks++; if (fi !== 1) begin fails++; $display("FAIL basic_first_high: got %0d want 1", fi); end
        measure(1, ha, hb, ps, pd, ov, fi);
        checks++; if (ha + hb !== 0) begin fails++; $display("FAIL duty0_ch1: got %0d want 0", ha + hb); end
        checks++; if (pd !== 0) begin fails++; $display("FAIL basic_pending: got %0d want 0", pd); end
    endtask

    task automatic test_duty_limits();
        int ha, hb, ps, pd, ov, fi;
        load(5'd5, 5'd25, 2'b11, 2'b00);
        sync_wrap();
        measure(1, ha, hb, ps, pd, ov, fi);
        checks++; if (ha !== PERIOD) begin fails++; $display("FAIL full_duty_p1: got %0d want %0d", ha, PERIOD); end
        checks++; if (hb !== 0) begin fails++; $display("FAIL full_duty_b: got %0d want 0", hb); end
        measure(1, ha, hb, ps, pd, ov, fi);
        checks++; if (ha !== PERIOD) begin fails++; $display("FAIL full_duty_p2: got %0d want %0d", ha, PERIOD); end
        measure(0, ha, hb, ps, pd, ov, fi);
        checks++; if (ha !== 5) begin fails++; $display("FAIL limits_ch0_a: got %0d want 5", ha); end
    endtask

    task automatic test_midperiod_update();
        int ha = 0, pcnt = 0, pbad = 0, hb, ps, pd, ov, fi;
        for (int i = 1; i <= PERIOD; i++) begin
            @(negedge clk);
            ha += int'(bus.m_a[0]);
            pcnt += int'(bus.upd_pending);
            if (bus.upd_pending !== (i >= 9 && i <= 19)) pbad++;
            if (i == 8) begin drive(5'd15, 5'd25, 2'b11, 2'b00); bus.upd_req = 1'b1; end
            if (i == 9) bus.upd_req = 1'b0;
        end
        checks++; if (ha !== 5) begin fails++; $display("FAIL mid_update_old_duty: got %0d want 5", ha); end
        checks++; if (pcnt !== 11) begin fails++; $display("FAIL mid_update_pending_len: got %0d want 11", pcnt); end
        checks++; if (pbad !== 0) begin fails++; $display("FAIL mid_update_pending_pos: got %0d bad cycles want 0", pbad); end
        checks++; if (bus.period_start !== 1'b1) begin fails++; $display("FAIL mid_update_wrap: got %b want 1", bus.period_start); end
        measure(0, ha, hb, ps, pd, ov, fi);
        checks++; if (ha !== 15) begin fails++; $display("FAIL mid_update_new_duty: got %0d want 15", ha); end
    endtask

    task automatic test_mid_reset();
        int first = 0, hi = 0;
        repeat (7) @(negedge clk);
        checks++; if (bus.m_a[0] !== 1'b1) begin fails++; $display("FAIL mid_reset_pre: got %b want 1", bus.m_a[0]); end
        rst = 1'b1;
        #1;
        checks++; if ({bus.m_a, bus.m_b} !== 4'b0000) begin fails++; $display("FAIL mid_reset_async: got %b want 0000", {bus.m_a, bus.m_b}); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int j = 1; j <= 3 * PERIOD; j++) begin
            @(negedge clk);
            hi += int'(|{bus.m_a, bus.m_b});
            if (bus.period_start) begin first = j; break; end
        end
        checks++; if (first !== PERIOD) begin fails++; $display("FAIL mid_reset_restart: got %0d want %0d", first, PERIOD); end
        checks++; if (hi !== 0) begin fails++; $display("FAIL mid_reset_active_cleared: got %0d want 0", hi); end
    endtask

    task automatic test_wrap_load();
        int pcnt = 0, ha, hb, ps, pd, ov, fi;
        for (int i = 1; i <= PERIOD; i++) begin
            @(negedge clk);
            pcnt += int'(bus.upd_pending);
            if (i == 19) begin drive(5'd15, 5'd25, 2'b11, 2'b10); bus.upd_req = 1'b1; end
            if (i == 20) bus.upd_req = 1'b0;
        end
        measure(1, ha, hb, ps, pd, ov, fi);
        checks++; if (pcnt + pd !== 0) begin fails++; $display("FAIL wrap_load_pending: got %0d want 0", pcnt + pd); end
        checks++; if (ha !== PERIOD) begin fails++; $display("FAIL brake_a: got %0d want %0d", ha, PERIOD); end
        checks++; if (hb !== PERIOD) begin fails++; $display("FAIL brake_b: got %0d want %0d", hb, PERIOD); end
        measure(0, ha, hb, ps, pd, ov, fi);
        checks++; if (ha !== 15) begin fails++; $display("FAIL wrap_load_ch0: got %0d want 15", ha); end
        checks++; if (ov !== 0) begin fails++; $display("FAIL no_shoot_through: got %0d want 0", ov); end
    endtask

    task automatic test_reversal();
        int ha, hb, ps, pd, ov, fi;
        load(5'd10, 5'd0, 2'b11, 2'b00);
        sync_wrap();
        measure(0, ha, hb, ps, pd, ov, fi);
        checks++; if (ha !== 10 || hb !== 0) begin fails++; $display("FAIL fwd10: got a=%0d b=%0d want a=10 b=0", ha, hb); end
        load(5'd10, 5'd0, 2'b10, 2'b00);
        sync_wrap();
        measure(0, ha, hb, ps, pd, ov, fi);
        checks++; if (ha !== 0) begin fails++; $display("FAIL rev_a: got %0d want 0", ha); end
        checks++; if (hb !== EXP_REV_HIGH) begin fails++; $display("FAIL rev_b_high: got %0d want %0d", hb, EXP_REV_HIGH); end
        checks++; if (fi !== EXP_REV_FIRST) begin fails++; $display("FAIL rev_first_high: got %0d want %0d", fi, EXP_REV_FIRST); end
        measure(0, ha, hb, ps, pd, ov, fi);
        checks++; if (hb !== 10 || fi !== 1) begin fails++; $display("FAIL rev_steady: got b=%0d first=%0d want b=10 first=1", hb, fi); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_duty_limits();
        test_midperiod_update();
        test_mid_reset();
        test_wrap_load();
        test_reversal();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
